// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the Benzaiten RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback over one shared memory port.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_len,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [3:0] C_ILL    = 4'd0;
    localparam logic [3:0] C_OP     = 4'd1;
    localparam logic [3:0] C_OPIMM  = 4'd2;
    localparam logic [3:0] C_LUI    = 4'd3;
    localparam logic [3:0] C_AUIPC  = 4'd4;
    localparam logic [3:0] C_JAL    = 4'd5;
    localparam logic [3:0] C_JALR   = 4'd6;
    localparam logic [3:0] C_BRANCH = 4'd7;
    localparam logic [3:0] C_LOAD   = 4'd8;
    localparam logic [3:0] C_STORE  = 4'd9;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    logic [2:0] state_q, state_d;
    logic [3:0] cls_q, cls_d;
    logic [2:0] len_q, len_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] decCls;
    logic [2:0] decLen;
    logic       decBadWidth;
    logic       timeoutHit;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    always_comb begin
        decCls      = C_ILL;
        decLen      = 3'd4;
        decBadWidth = 1'b0;
        case (instr[6:0])
            7'b0010011: decCls = C_OPIMM;
            7'b0110011: decCls = C_OP;
            7'b0110111: decCls = C_LUI;
            7'b0010111: decCls = C_AUIPC;
            7'b1101111: decCls = C_JAL;
            7'b1100111: decCls = C_JALR;
            7'b1100011: decCls = C_BRANCH;
            7'b0000011: begin
                decCls = C_LOAD;
                case (instr[14:12])
                    3'b000, 3'b100: decLen = 3'd1;
                    3'b001, 3'b101: decLen = 3'd2;
                    3'b010:         decLen = 3'd4;
                    default:        decBadWidth = 1'b1;
                endcase
            end
            7'b0100011: begin
                decCls = C_STORE;
                case (instr[14:12])
                    3'b000:  decLen = 3'd1;
                    3'b001:  decLen = 3'd2;
                    3'b010:  decLen = 3'd4;
                    default: decBadWidth = 1'b1;
                endcase
            end
            default: decCls = C_ILL;
        endcase
    end

    // A limit of zero disables the timeout; a same-cycle mem_ready always wins.
    assign timeoutHit = (MEM_TIMEOUT != 0) && (cnt_q == TIMEOUT_LIM) && !mem_ready;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        len_d   = len_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeoutHit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end
            end
            S_DECODE: begin
                cls_d = decCls;
                len_d = decLen;
                if (decCls == C_ILL) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end else if (decBadWidth) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_FETCH;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                end else if (timeoutHit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q || mem_ready) begin
            cnt_d = 8'd0;
        end else if (mem_req) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_ILL;
            len_q   <= 3'd4;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            len_q   <= len_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are forced low while reset is held so a pending write is abandoned.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_len      = 3'd0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        retire       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    mem_len = 3'd4;
                    ir_we   = mem_ready;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_OP: begin
                            rf_we = 1'b1;
                        end
                        C_OPIMM: begin
                            rf_we     = 1'b1;
                            alu_b_sel = 1'b1;
                        end
                        C_LUI: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b11;
                        end
                        C_AUIPC: begin
                            rf_we     = 1'b1;
                            alu_a_sel = 1'b1;
                            alu_b_sel = 1'b1;
                        end
                        C_JAL: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b10;
                            pc_sel = 2'b01;
                        end
                        C_JALR: begin
                            rf_we     = 1'b1;
                            wb_sel    = 2'b10;
                            alu_b_sel = 1'b1;
                            pc_sel    = 2'b10;
                        end
                        C_BRANCH: pc_sel = branch_taken ? 2'b01 : 2'b00;
                        default:  alu_b_sel = 1'b1;
                    endcase
                    if (cls_q != C_LOAD && cls_q != C_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_len      = len_q;
                    mem_we       = (cls_q == C_STORE);
                    alu_b_sel    = 1'b1;
                    if (mem_ready && cls_q == C_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = 2'b01;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer, built with a short memory
// timeout so the timeout trap can be reached quickly.
module tb_control_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_len;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_a103;
    localparam logic [31:0] I_BEQ   = 32'h0020_8063;
    localparam logic [31:0] I_SW    = 32'h0020_a023;
    localparam logic [31:0] I_SBAD  = 32'h0020_b023;
    localparam logic [31:0] I_JAL   = 32'h0000_006f;
    localparam logic [31:0] I_ILL   = 32'h0000_007f;

    control_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic rdy, input logic [31:0] ins, input logic bt);
        mem_ready    = rdy;
        instr        = ins;
        branch_taken = bt;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_trap", 32'(trap), 32'd0);
        checkOutput("rst_cause", 32'(trap_cause), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_pc_we", 32'(pc_we), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        mem_ready    = 1'b0;
        instr        = 32'd0;
        branch_taken = 1'b0;
        doReset();

        checkOutput("first_mem_req", 32'(mem_req), 32'd1);
        checkOutput("fetch_len", 32'(mem_len), 32'd4);
        checkOutput("fetch_addr_sel", 32'(mem_addr_sel), 32'd0);
        checkOutput("fetch_no_ir_we", 32'(ir_we), 32'd0);

        // addi with mem_ready high: FETCH, DECODE, EXEC, FETCH
        applyStimulus(1'b1, I_ADDI, 1'b0);
        checkOutput("addi_fetch_state", 32'(state), 32'd0);
        checkOutput("addi_ir_we", 32'(ir_we), 32'd1);
        checkOutput("addi_fetch_retire", 32'(retire), 32'd0);
        tick();
        checkOutput("addi_decode_state", 32'(state), 32'd1);
        checkOutput("addi_decode_req", 32'(mem_req), 32'd0);
        tick();
        checkOutput("addi_exec_state", 32'(state), 32'd2);
        checkOutput("addi_rf_we", 32'(rf_we), 32'd1);
        checkOutput("addi_wb_sel", 32'(wb_sel), 32'd0);
        checkOutput("addi_alu_a", 32'(alu_a_sel), 32'd0);
        checkOutput("addi_alu_b", 32'(alu_b_sel), 32'd1);
        checkOutput("addi_retire", 32'(retire), 32'd1);
        checkOutput("addi_pc_we", 32'(pc_we), 32'd1);
        checkOutput("addi_pc_sel", 32'(pc_sel), 32'd0);
        tick();
        checkOutput("addi_back_fetch", 32'(state), 32'd0);

        // lw with two wait cycles in MEM: 7 cycles total
        applyStimulus(1'b1, I_LW, 1'b0);
        checkOutput("lw_ir_we", 32'(ir_we), 32'd1);
        tick();
        checkOutput("lw_decode", 32'(state), 32'd1);
        tick();
        applyStimulus(1'b0, I_LW, 1'b0);
        checkOutput("lw_exec", 32'(state), 32'd2);
        checkOutput("lw_exec_alu_b", 32'(alu_b_sel), 32'd1);
        checkOutput("lw_exec_no_retire", 32'(retire), 32'd0);
        checkOutput("lw_exec_no_pc_we", 32'(pc_we), 32'd0);
        tick();
        checkOutput("lw_mem1_state", 32'(state), 32'd3);
        checkOutput("lw_mem1_req", 32'(mem_req), 32'd1);
        checkOutput("lw_mem1_len", 32'(mem_len), 32'd4);
        checkOutput("lw_mem1_we", 32'(mem_we), 32'd0);
        checkOutput("lw_mem1_addr_sel", 32'(mem_addr_sel), 32'd1);
        checkOutput("lw_mem1_alu_b", 32'(alu_b_sel), 32'd1);
        tick();
        checkOutput("lw_mem2_state", 32'(state), 32'd3);
        tick();
        applyStimulus(1'b1, I_LW, 1'b0);
        checkOutput("lw_mem3_state", 32'(state), 32'd3);
        checkOutput("lw_mem3_no_retire", 32'(retire), 32'd0);
        tick();
        checkOutput("lw_wb_state", 32'(state), 32'd4);
        checkOutput("lw_wb_rf_we", 32'(rf_we), 32'd1);
        checkOutput("lw_wb_sel", 32'(wb_sel), 32'd1);
        checkOutput("lw_wb_retire", 32'(retire), 32'd1);
        checkOutput("lw_wb_pc_we", 32'(pc_we), 32'd1);
        tick();
        checkOutput("lw_cycle7_fetch", 32'(state), 32'd0);

        // beq taken then not taken
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, I_BEQ, 1'b0);
            tick();
            checkOutput("beq_decode_retire", 32'(retire), 32'd0);
            tick();
            applyStimulus(1'b1, I_BEQ, (k == 0));
            checkOutput("beq_exec_state", 32'(state), 32'd2);
            checkOutput("beq_pc_sel", 32'(pc_sel), (k == 0) ? 32'd1 : 32'd0);
            checkOutput("beq_rf_we", 32'(rf_we), 32'd0);
            checkOutput("beq_retire", 32'(retire), 32'd1);
            tick();
        end

        // jal
        applyStimulus(1'b1, I_JAL, 1'b0);
        tick();
        tick();
        checkOutput("jal_wb_sel", 32'(wb_sel), 32'd2);
        checkOutput("jal_pc_sel", 32'(pc_sel), 32'd1);
        checkOutput("jal_rf_we", 32'(rf_we), 32'd1);
        tick();

        // sw with zero-wait memory: 4 cycles, retire in MEM
        applyStimulus(1'b1, I_SW, 1'b0);
        tick();
        tick();
        checkOutput("sw_exec_retire", 32'(retire), 32'd0);
        tick();
        checkOutput("sw_mem_state", 32'(state), 32'd3);
        checkOutput("sw_mem_we", 32'(mem_we), 32'd1);
        checkOutput("sw_mem_len", 32'(mem_len), 32'd4);
        checkOutput("sw_mem_retire", 32'(retire), 32'd1);
        checkOutput("sw_mem_pc_we", 32'(pc_we), 32'd1);
        tick();
        checkOutput("sw_back_fetch", 32'(state), 32'd0);

        // reset in the middle of a pending store write
        tick();
        tick();
        applyStimulus(1'b0, I_SW, 1'b0);
        tick();
        checkOutput("swrst_mem_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("swrst_req_dropped", 32'(mem_req), 32'd0);
        checkOutput("swrst_we_dropped", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("swrst_fetch", 32'(state), 32'd0);
        checkOutput("swrst_fetch_req", 32'(mem_req), 32'd1);

        // store with funct3 = 011 traps with cause 10
        applyStimulus(1'b1, I_SBAD, 1'b0);
        tick();
        checkOutput("sbad_decode_pc_we", 32'(pc_we), 32'd0);
        tick();
        checkOutput("sbad_trap_state", 32'(state), 32'd5);
        checkOutput("sbad_trap", 32'(trap), 32'd1);
        checkOutput("sbad_cause", 32'(trap_cause), 32'd2);
        checkOutput("sbad_pc_we", 32'(pc_we), 32'd0);
        checkOutput("sbad_mem_req", 32'(mem_req), 32'd0);
        doReset();

        // illegal opcode: cause 01, trap holds for 20 cycles
        applyStimulus(1'b1, I_ILL, 1'b0);
        tick();
        tick();
        checkOutput("ill_cause", 32'(trap_cause), 32'd1);
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("ill_trap_hold", 32'(trap), 32'd1);
            checkOutput("ill_state_hold", 32'(state), 32'd5);
            checkOutput("ill_no_retire", 32'(retire), 32'd0);
        end
        doReset();
        checkOutput("ill_rst_fetch", 32'(state), 32'd0);

        // fetch timeout: 5 request cycles with mem_ready low
        applyStimulus(1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("to_waiting", 32'(state), 32'd0);
            tick();
        end
        checkOutput("to_cycle5_fetch", 32'(state), 32'd0);
        checkOutput("to_cycle5_req", 32'(mem_req), 32'd1);
        tick();
        checkOutput("to_trap_state", 32'(state), 32'd5);
        checkOutput("to_cause", 32'(trap_cause), 32'd3);
        checkOutput("to_trap", 32'(trap), 32'd1);

        // mem_ready in the fifth cycle beats the timeout
        applyStimulus(1'b0, I_ADDI, 1'b0);
        doReset();
        for (int k = 0; k < 4; k++) tick();
        applyStimulus(1'b1, I_ADDI, 1'b0);
        checkOutput("late_ready_ir_we", 32'(ir_we), 32'd1);
        tick();
        checkOutput("late_ready_decode", 32'(state), 32'd1);
        checkOutput("late_ready_no_trap", 32'(trap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control FSM for the Benzaiten RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select around the instruction register, register file, ALU, PC and the shared single-port memory, and uses that one memory port for both fetch and data access. It classifies the instruction held in the IR by opcode and funct3, and traps on illegal opcodes, illegal memory widths and memory timeouts.

## Interface
- MEM_TIMEOUT, 255: wait cycles allowed on one memory request before a timeout trap; 0 disables the timeout.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IR output; stable from the cycle after ir_we onward.
- mem_ready  in  1  memory completes the current request this cycle; may be combinational from mem_req.
- branch_taken  in  1  comparator result for the branch in the IR; sampled only in EXEC.
- mem_req  out  1  memory request.
- mem_we  out  1  write request, valid with mem_req.
- mem_len  out  3  access size in bytes: 1, 2 or 4.
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_sel  out  2  next-PC source: 00 = PC+4, 01 = PC+imm, 10 = ALU result & ~1.
- alu_a_sel  out  1  ALU input A: 0 = rs1, 1 = PC.
- alu_b_sel  out  1  ALU input B: 0 = rs2, 1 = imm.
- rf_we  out  1  register-file write.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC+4, 11 = imm.
- retire  out  1  one-cycle pulse, once per completed instruction.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  01 = illegal opcode, 10 = illegal funct3 on load/store, 11 = memory timeout.
- state  out  3  current state, for debug: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.

## Operation
- Opcode classes:
  - OPIMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111
  - JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011
  - any other opcode is illegal.
- FETCH:
  - Drives mem_req = 1, mem_addr_sel = 0, mem_we = 0, mem_len = 4.
  - On mem_ready: ir_we = 1 in the same cycle, then go to DECODE.
- DECODE:
  - Registers the instruction class and the access length.
  - Load funct3 mapping: 000 and 100 give length 1; 001 and 101 give length 2; 010 gives length 4; any other value traps with cause 10.
  - Store funct3 mapping: 000, 001 and 010 give lengths 1, 2 and 4; any other value traps with cause 10.
  - Illegal opcode goes to TRAP with cause 01. Otherwise go to EXEC.
- EXEC, one cycle. Every non-memory class also retires here and returns to FETCH, with pc_we = 1 and pc_sel = 00 unless stated otherwise:
  - OP: rf_we = 1, wb_sel = 00, alu_a_sel = 0, alu_b_sel = 0.
  - OPIMM: same as OP except alu_b_sel = 1.
  - LUI: rf_we = 1, wb_sel = 11.
  - AUIPC: rf_we = 1, wb_sel = 00, alu_a_sel = 1, alu_b_sel = 1.
  - JAL: rf_we = 1, wb_sel = 10, pc_sel = 01.
  - JALR: rf_we = 1, wb_sel = 10, alu_a_sel = 0, alu_b_sel = 1, pc_sel = 10.
  - BRANCH: pc_sel = 01 if branch_taken, otherwise 00; rf_we = 0.
  - LOAD and STORE: alu_a_sel = 0, alu_b_sel = 1, no retire; go to MEM.
- MEM:
  - Drives mem_req = 1, mem_addr_sel = 1, mem_len = latched length, mem_we = 1 for stores only.
  - ALU selects stay as in EXEC.
  - On mem_ready for a store: pc_we = 1, pc_sel = 00, retire, go to FETCH.
  - On mem_ready for a load: go to WB.
- WB: rf_we = 1, wb_sel = 01, pc_we = 1, pc_sel = 00, retire, go to FETCH.
- TRAP:
  - Absorbing state; only rst leaves it.
  - All strobes are 0; trap = 1; trap_cause holds the value set on entry.
- Timeout:
  - An 8-bit counter increments on every FETCH or MEM cycle with mem_req = 1 and mem_ready = 0.
  - It clears on mem_ready and on every state change.
  - When the counter equals MEM_TIMEOUT with mem_ready = 0, go to TRAP with cause 11.
  - mem_ready in the same cycle wins over the timeout.
- Outputs not listed for a state are 0. Strobes and selects are decoded combinationally from the state and the latched class; ir_we and the MEM/FETCH transitions also depend on mem_ready.

## Timing
- Reset:
  - The cycle after rst is sampled high: state = FETCH, trap = 0, trap_cause = 00, counter = 0.
  - All strobes are 0 while rst is high.
- mem_req is asserted in the first cycle after rst deasserts.
- Reset mid-operation, in any state including MEM with a write pending: the request is abandoned and the next cycle is a fresh FETCH.
- Cycle counts with zero-wait memory (mem_ready high in the first request cycle):
  - ALU, jump and branch instructions: 3 cycles (FETCH, DECODE, EXEC).
  - Stores: 4 cycles.
  - Loads: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- retire and pc_we are asserted in the final cycle of each instruction, and never in the same cycle as ir_we.
- A trap is taken on the edge that ends DECODE, or on the edge that ends the timeout cycle. No retire and no pc_we are issued for a trapping instruction.

## Test plan
- Reset, then addi (0x00500093) with mem_ready tied high:
  - States follow 0, 1, 2, 0.
  - EXEC shows rf_we = 1, wb_sel = 00, alu_b_sel = 1, retire = 1.
- lw (0x0000a103), with mem_ready low for 2 cycles in MEM:
  - MEM lasts 3 cycles with mem_len = 4 and mem_we = 0.
  - WB shows rf_we = 1 and wb_sel = 01; 7 cycles in total.
- beq:
  - branch_taken = 1 gives pc_sel = 01; branch_taken = 0 gives pc_sel = 00.
  - rf_we = 0 in both cases; 1 retire per instruction.
- Store funct3 = 011 (0x0020b023):
  - Goes to TRAP after DECODE with trap_cause = 10; pc_we is never asserted.
- Opcode 0x7f:
  - trap_cause = 01; trap stays high for 20 cycles.
  - rst returns the block to FETCH with trap = 0.
- MEM_TIMEOUT = 4, mem_ready held low in FETCH:
  - TRAP entered after 5 request cycles with cause 11.
  - Repeat with mem_ready rising in the 5th cycle: no trap, ir_we = 1.
